bsr_chain_router: RTL and testbench



---
 rtl/jtag_pkg.sv | 15 +
 rtl/bsr_bypass_cell.sv | 31 +++
 rtl/bsr_chain_router.sv | 153 +++++++++++++++
 tb/tb_bsr_chain_router.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared types and constants for the boundary-scan chain router.
package jtag_pkg;

    // Router FSM states.
    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        BREAK  = 2'd3
    } bsr_rtr_state_t;

    // Value loaded into the bypass register on capture.
    localparam logic BYP_CAPTURE_VAL = 1'b0;

endpackage : jtag_pkg

// File: rtl/bsr_bypass_cell.sv
// Single-bit bypass register: capture loads a fixed value, shift loads tdi.
module bsr_bypass_cell
    import jtag_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_capture,
    input  logic i_shift,
    input  logic i_tdi,
    output logic o_q
);

    logic r_q;

    // Capture has priority over shift; the cell only moves while enabled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            if (i_capture) begin
                r_q <= BYP_CAPTURE_VAL;
            end else if (i_shift) begin
                r_q <= i_tdi;
            end
        end
    end

    assign o_q = r_q;

endmodule : bsr_bypass_cell

// File: rtl/bsr_chain_router.sv
// Routes TAP strobes and TDO between the TAP and CHAIN_NUM boundary-scan chains,
// switching break-before-make through DRAIN and BREAK so no chain changes mid-shift.
module bsr_chain_router
    import jtag_pkg::*;
#(
    parameter int unsigned CHAIN_NUM = 4,
    parameter int unsigned SEL_WIDTH = $clog2(CHAIN_NUM)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [SEL_WIDTH-1:0] i_sel_in,
    input  logic                 i_sel_load,
    input  logic                 i_shift_en,
    input  logic                 i_capture_en,
    input  logic                 i_update_en,
    input  logic                 i_tdi,
    input  logic [CHAIN_NUM-1:0] i_chain_tdo,
    output logic [CHAIN_NUM-1:0] o_chain_sel,
    output logic [CHAIN_NUM-1:0] o_chain_shift_en,
    output logic [CHAIN_NUM-1:0] o_chain_capture_en,
    output logic [CHAIN_NUM-1:0] o_chain_update_en,
    output logic                 o_tdo,
    output logic [SEL_WIDTH-1:0] o_active_sel,
    output logic                 o_bypass_active,
    output logic                 o_sel_busy,
    output logic                 o_sel_err
);

    // One extra bit so the range check never wraps when CHAIN_NUM is a power of two.
    localparam int unsigned LP_CMP_W = SEL_WIDTH + 1;
    localparam logic [LP_CMP_W-1:0] LP_CHAIN_LIMIT = LP_CMP_W'(CHAIN_NUM);
    localparam logic [CHAIN_NUM-1:0] LP_ONE = {{(CHAIN_NUM-1){1'b0}}, 1'b1};

    bsr_rtr_state_t r_state;
    bsr_rtr_state_t w_state_nxt;

    logic [SEL_WIDTH-1:0] r_pending;
    logic [SEL_WIDTH-1:0] w_pending_nxt;
    logic [CHAIN_NUM-1:0] r_chain_sel;
    logic [CHAIN_NUM-1:0] w_chain_sel_nxt;
    logic [SEL_WIDTH-1:0] r_active_sel;
    logic [SEL_WIDTH-1:0] w_active_sel_nxt;
    logic                 r_bypass_active;
    logic                 r_sel_busy;
    logic                 r_sel_err;
    logic                 w_sel_err_nxt;
    logic                 r_tdo;
    logic                 w_tdo_nxt;

    logic                 w_strobe_any;
    logic                 w_pending_in_range;
    logic [CHAIN_NUM-1:0] w_pending_onehot;
    logic                 w_byp_q;

    assign w_strobe_any       = i_shift_en | i_capture_en | i_update_en;
    assign w_pending_in_range = ({1'b0, r_pending} < LP_CHAIN_LIMIT);
    assign w_pending_onehot   = LP_ONE << r_pending;

    bsr_bypass_cell u_bypass (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_en      (r_bypass_active),
        .i_capture (i_capture_en),
        .i_shift   (i_shift_en),
        .i_tdi     (i_tdi),
        .o_q       (w_byp_q)
    );

    // Next-state, selection and TDO source decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_pending_nxt    = r_pending;
        w_chain_sel_nxt  = r_chain_sel;
        w_active_sel_nxt = r_active_sel;
        w_sel_err_nxt    = 1'b0;
        w_tdo_nxt        = 1'b0;

        case (r_state)
            BYPASS: begin
                w_tdo_nxt = w_byp_q;
                if (i_sel_load) begin
                    w_pending_nxt = i_sel_in;
                    w_state_nxt   = DRAIN;
                end
            end
            ACTIVE: begin
                w_tdo_nxt = i_chain_tdo[r_active_sel];
                if (i_sel_load) begin
                    w_pending_nxt = i_sel_in;
                    w_state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                // Old route stays live; a drain out of bypass keeps feeding the bypass bit.
                w_tdo_nxt = r_bypass_active ? w_byp_q : i_chain_tdo[r_active_sel];
                if (!w_strobe_any) begin
                    w_state_nxt      = BREAK;
                    w_chain_sel_nxt  = '0;
                    w_active_sel_nxt = '0;
                end
            end
            BREAK: begin
                if (w_pending_in_range) begin
                    w_state_nxt      = ACTIVE;
                    w_chain_sel_nxt  = w_pending_onehot;
                    w_active_sel_nxt = r_pending;
                end else begin
                    w_state_nxt   = BYPASS;
                    w_sel_err_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt      = BYPASS;
                w_chain_sel_nxt  = '0;
                w_active_sel_nxt = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= BYPASS;
            r_pending       <= '0;
            r_chain_sel     <= '0;
            r_active_sel    <= '0;
            r_bypass_active <= 1'b1;
            r_sel_busy      <= 1'b0;
            r_sel_err       <= 1'b0;
            r_tdo           <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pending       <= w_pending_nxt;
            r_chain_sel     <= w_chain_sel_nxt;
            r_active_sel    <= w_active_sel_nxt;
            r_bypass_active <= (w_chain_sel_nxt == '0);
            r_sel_busy      <= (w_state_nxt == DRAIN) || (w_state_nxt == BREAK);
            r_sel_err       <= w_sel_err_nxt;
            r_tdo           <= w_tdo_nxt;
        end
    end

    assign o_chain_sel        = r_chain_sel;
    assign o_chain_shift_en   = {CHAIN_NUM{i_shift_en}}   & r_chain_sel;
    assign o_chain_capture_en = {CHAIN_NUM{i_capture_en}} & r_chain_sel;
    assign o_chain_update_en  = {CHAIN_NUM{i_update_en}}  & r_chain_sel;
    assign o_tdo              = r_tdo;
    assign o_active_sel       = r_active_sel;
    assign o_bypass_active    = r_bypass_active;
    assign o_sel_busy         = r_sel_busy;
    assign o_sel_err          = r_sel_err;

endmodule : bsr_chain_router

// File: tb/tb_bsr_chain_router.sv
// Bench for bsr_chain_router: a 4-chain and a 5-chain instance share stimulus
// and are compared every cycle against a selection/phase model.
module tb_bsr_chain_router;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel_load;
    logic       shift_en;
    logic       capture_en;
    logic       update_en;
    logic       tdi;
    logic [2:0] sel;
    logic [4:0] ctdo;

    logic [3:0] a_cs, a_sh, a_ca, a_up;
    logic [1:0] a_as;
    logic       a_tdo, a_ba, a_busy, a_err;
    logic [4:0] b_cs, b_sh, b_ca, b_up;
    logic [2:0] b_as;
    logic       b_tdo, b_ba, b_busy, b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsr_chain_router #(.CHAIN_NUM(4), .SEL_WIDTH(2)) u_a (
        .i_clk(clk), .i_reset(reset), .i_sel_in(sel[1:0]), .i_sel_load(sel_load),
        .i_shift_en(shift_en), .i_capture_en(capture_en), .i_update_en(update_en),
        .i_tdi(tdi), .i_chain_tdo(ctdo[3:0]),
        .o_chain_sel(a_cs), .o_chain_shift_en(a_sh), .o_chain_capture_en(a_ca),
        .o_chain_update_en(a_up), .o_tdo(a_tdo), .o_active_sel(a_as),
        .o_bypass_active(a_ba), .o_sel_busy(a_busy), .o_sel_err(a_err)
    );

    bsr_chain_router #(.CHAIN_NUM(5), .SEL_WIDTH(3)) u_b (
        .i_clk(clk), .i_reset(reset), .i_sel_in(sel), .i_sel_load(sel_load),
        .i_shift_en(shift_en), .i_capture_en(capture_en), .i_update_en(update_en),
        .i_tdi(tdi), .i_chain_tdo(ctdo),
        .o_chain_sel(b_cs), .o_chain_shift_en(b_sh), .o_chain_capture_en(b_ca),
        .o_chain_update_en(b_up), .o_tdo(b_tdo), .o_active_sel(b_as),
        .o_bypass_active(b_ba), .o_sel_busy(b_busy), .o_sel_err(b_err)
    );

    // Model: idx is the routed chain (-1 = none); ph 0 steady, 1 draining, 2 broken.
    typedef struct {
        int idx;
        int ph;
        int pend;
        bit tdo;
        bit byp;
        bit err;
    } m_t;

    m_t ma, mb;

    function automatic m_t m_reset();
        m_t m;
        m.idx = -1; m.ph = 0; m.pend = 0; m.tdo = 1'b0; m.byp = 1'b0; m.err = 1'b0;
        return m;
    endfunction

    function automatic m_t m_step(m_t m, int cn, int s);
        m_t n = m;
        if (reset) return m_reset();
        n.err = 1'b0;
        if (m.ph == 2)      n.tdo = 1'b0;
        else if (m.idx >= 0) n.tdo = ctdo[m.idx];
        else                n.tdo = m.byp;
        if (m.idx < 0) begin
            if (capture_en)    n.byp = 1'b0;
            else if (shift_en) n.byp = tdi;
        end
        if (m.ph == 0) begin
            if (sel_load) begin n.pend = s; n.ph = 1; end
        end else if (m.ph == 1) begin
            if (!(shift_en | capture_en | update_en)) begin n.ph = 2; n.idx = -1; end
        end else begin
            n.ph = 0;
            if (m.pend < cn) n.idx = m.pend;
            else begin n.idx = -1; n.err = 1'b1; end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input m_t m,
                           input logic [31:0] cs, input logic [31:0] sh,
                           input logic [31:0] ca, input logic [31:0] up,
                           input logic [31:0] as, input logic tdo_v, input logic ba,
                           input logic busy, input logic err);
        logic [31:0] ecs;
        ecs = (m.idx < 0) ? 32'd0 : (32'd1 << m.idx);
        chk({tag, ".chain_sel"}, cs, ecs);
        chk({tag, ".shift_en"}, sh, shift_en ? ecs : 32'd0);
        chk({tag, ".capture_en"}, ca, capture_en ? ecs : 32'd0);
        chk({tag, ".update_en"}, up, update_en ? ecs : 32'd0);
        chk({tag, ".active_sel"}, as, (m.idx < 0) ? 32'd0 : 32'(m.idx));
        chk({tag, ".tdo"}, 32'(tdo_v), 32'(m.tdo));
        chk({tag, ".bypass_active"}, 32'(ba), (m.idx < 0) ? 32'd1 : 32'd0);
        chk({tag, ".sel_busy"}, 32'(busy), (m.ph != 0) ? 32'd1 : 32'd0);
        chk({tag, ".sel_err"}, 32'(err), 32'(m.err));
    endtask

    // One clock: advance both models on the edge, then compare just after it.
    task automatic tick();
        @(posedge clk);
        ma = m_step(ma, 4, int'(sel[1:0]));
        mb = m_step(mb, 5, int'(sel));
        #1;
        cmp_dut("A", ma, 32'(a_cs), 32'(a_sh), 32'(a_ca), 32'(a_up), 32'(a_as),
                a_tdo, a_ba, a_busy, a_err);
        cmp_dut("B", mb, 32'(b_cs), 32'(b_sh), 32'(b_ca), 32'(b_up), 32'(b_as),
                b_tdo, b_ba, b_busy, b_err);
    endtask

    task automatic select(input logic [2:0] s);
        sel = s; sel_load = 1'b1; tick();
        sel_load = 1'b0; tick(); tick();
    endtask

    initial begin
        ma = m_reset(); mb = m_reset();
        reset = 1'b1; sel_load = 1'b0; shift_en = 1'b0; capture_en = 1'b0;
        update_en = 1'b0; tdi = 1'b0; sel = 3'd0; ctdo = 5'd0;
        tick(); tick();

        // Reset values, plus reset winning over a simultaneous load.
        sel_load = 1'b1; sel = 3'd2; tick();
        chk("rst_chain_sel", 32'(a_cs), 32'h0);
        chk("rst_bypass", 32'(a_ba), 32'h1);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_tdo", 32'(a_tdo), 32'h0);
        reset = 1'b0;

        // Basic switch to chain 2: busy two cycles, one-hot on the third edge.
        tick();
        chk("sw_busy1", 32'(a_busy), 32'h1);
        sel_load = 1'b0; tick();
        chk("sw_busy2", 32'(a_busy), 32'h1);
        chk("sw_break", 32'(a_cs), 32'h0);
        tick();
        chk("sw_sel", 32'(a_cs), 32'h4);
        chk("sw_busy3", 32'(a_busy), 32'h0);
        chk("sw_active_sel", 32'(a_as), 32'h2);

        // Mid-shift request: chain 1 holds while shifting, one empty cycle, then chain 3.
        select(3'd1);
        chk("ms_start", 32'(a_cs), 32'h2);
        shift_en = 1'b1; sel = 3'd3; sel_load = 1'b1; tick();
        sel_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ms_hold", 32'(a_cs), 32'h2);
            chk("ms_sh3", 32'(a_sh[3]), 32'h0);
        end
        shift_en = 1'b0; tick();
        chk("ms_break", 32'(a_cs), 32'h0);
        tick();
        chk("ms_new", 32'(a_cs), 32'h8);

        // Request during DRAIN is ignored.
        sel = 3'd1; sel_load = 1'b1; tick();
        sel = 3'd2; tick();
        sel_load = 1'b0; tick(); tick();
        chk("ign_sel", 32'(a_cs), 32'h2);

        // TDO mux with chain 2 active.
        select(3'd2);
        ctdo = 5'b00100; tick();
        chk("mux_tdo1", 32'(a_tdo), 32'h1);
        ctdo = 5'b00000; tick();
        chk("mux_tdo0", 32'(a_tdo), 32'h0);

        // Out-of-range on the 5-chain instance, then bypass capture/shift.
        sel = 3'd6; sel_load = 1'b1; tick();
        sel_load = 1'b0; tick(); tick();
        chk("oor_err", 32'(b_err), 32'h1);
        chk("oor_cs", 32'(b_cs), 32'h0);
        chk("oor_ba", 32'(b_ba), 32'h1);
        tick();
        chk("oor_err_end", 32'(b_err), 32'h0);
        capture_en = 1'b1; tick();
        capture_en = 1'b0; shift_en = 1'b1; tdi = 1'b1; tick();
        chk("byp_tdo0", 32'(b_tdo), 32'h0);
        tdi = 1'b0; tick();
        chk("byp_tdo1", 32'(b_tdo), 32'h1);
        tdi = 1'b1; tick();
        chk("byp_tdo2", 32'(b_tdo), 32'h0);
        shift_en = 1'b0; tick();
        chk("byp_tdo3", 32'(b_tdo), 32'h1);

        // Reset landing on BREAK discards the pending selection.
        sel = 3'd1; sel_load = 1'b1; tick();
        sel_load = 1'b0; tick();
        chk("rb_break", 32'(a_cs), 32'h0);
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("rb_busy", 32'(a_busy), 32'h0);
        chk("rb_ba", 32'(a_ba), 32'h1);
        tick();
        chk("rb_still_byp", 32'(a_cs), 32'h0);
        select(3'd0);
        chk("rb_sel0", 32'(a_cs), 32'h1);

        // Reselect the active index still runs the break cycle.
        sel = 3'd0; sel_load = 1'b1; tick();
        sel_load = 1'b0; tick();
        chk("re_break", 32'(a_cs), 32'h0);
        tick();
        chk("re_sel", 32'(a_cs), 32'h1);

        // Strobe gating with update/capture on an active chain.
        update_en = 1'b1; capture_en = 1'b1; tick();
        chk("gate_upd", 32'(a_up), 32'h1);
        update_en = 1'b0; capture_en = 1'b0; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bsr_chain_router
